aes_gcm_ctr_scheduler: RTL and testbench

//  Sequences the pipelined AES-256 encryption core for one AES-GCM message.

---
 rtl/aes_sched_pkg.sv | 34 +++
 rtl/aes_gcm_ctr_scheduler_if.sv | 51 +++++
 rtl/aes_sched_track.sv | 58 +++++
 rtl/aes_gcm_ctr_scheduler.sv | 174 +++++++++++++++++
 tb/tb_aes_gcm_ctr_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sched_pkg
//  Description : Shared types and constants for the AES-GCM counter-block
//                scheduler: FSM state encoding, block/IV/counter widths,
//                the reserved J0 counter and the num_blocks clamp.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_sched_pkg;

    localparam int BLOCK_W = 128;
    localparam int IV_W    = 96;
    localparam int CTR_W   = 32;

    localparam logic [CTR_W-1:0] J0_CTR     = 32'h1;
    localparam logic [CTR_W-1:0] DATA_CTR0  = 32'h2;
    // Largest data block count: the last data counter is then 32'hFFFFFFFF,
    // so the inc32 counter never wraps back onto the J0 value.
    localparam logic [CTR_W-1:0] MAX_BLOCKS = 32'hFFFFFFFE;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE_J0   = 3'd1,
        ST_ISSUE_DATA = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_DONE       = 3'd4
    } sched_state_t;

    function automatic logic [CTR_W-1:0] clamp_blocks(input logic [CTR_W-1:0] n);
        return (n > MAX_BLOCKS) ? MAX_BLOCKS : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_gcm_ctr_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_gcm_ctr_scheduler_if
//  Description : Message/handshake bundle of the AES-GCM counter scheduler.
//                master : message source / keystream consumer side
//                slave  : the scheduler
//                Signals: start, iv, num_blocks, ks_pop (to scheduler);
//                aes_in_valid, aes_in_block, ks_valid, ks_is_j0, busy,
//                done, credit_err (from scheduler).
//                With AES_SCHED_ABORT_EN: abort (in), aborted (out).
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_gcm_ctr_scheduler_if;
    import aes_sched_pkg::*;

    logic                start;
    logic [IV_W-1:0]     iv;
    logic [CTR_W-1:0]    num_blocks;
    logic                ks_pop;
    logic                aes_in_valid;
    logic [BLOCK_W-1:0]  aes_in_block;
    logic                ks_valid;
    logic                ks_is_j0;
    logic                busy;
    logic                done;
    logic                credit_err;
`ifdef AES_SCHED_ABORT_EN
    logic                abort;
    logic                aborted;
`endif

    modport master (
        output start, iv, num_blocks, ks_pop,
`ifdef AES_SCHED_ABORT_EN
        output abort,
        input  aborted,
`endif
        input  aes_in_valid, aes_in_block, ks_valid, ks_is_j0, busy, done, credit_err
    );

    modport slave (
        input  start, iv, num_blocks, ks_pop,
`ifdef AES_SCHED_ABORT_EN
        input  abort,
        output aborted,
`endif
        output aes_in_valid, aes_in_block, ks_valid, ks_is_j0, busy, done, credit_err
    );

endinterface
`default_nettype wire

// File: rtl/aes_sched_track.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sched_track
//  Description : Latency-matched shadow of the AES pipeline. Each issued
//                block enters as {valid, is_j0} and leaves LATENCY cycles
//                later as the keystream write strobe and J0 marker.
//                Ports: clk, reset, i_valid, i_is_j0 -> o_valid, o_is_j0,
//                o_any_valid (some block is still inside after this cycle).
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sched_track #(
    parameter int LATENCY = 14
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_valid,
    input  wire logic i_is_j0,
    output logic      o_valid,
    output logic      o_is_j0,
    output logic      o_any_valid
);

    logic [LATENCY-1:0] r_valid;
    logic [LATENCY-1:0] r_is_j0;

    generate
        if (LATENCY == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid <= '0;
                    r_is_j0 <= '0;
                end else begin
                    r_valid <= i_valid;
                    r_is_j0 <= i_is_j0 & i_valid;
                end
            end
            assign o_any_valid = 1'b0;
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid <= '0;
                    r_is_j0 <= '0;
                end else begin
                    r_valid <= {r_valid[LATENCY-2:0], i_valid};
                    r_is_j0 <= {r_is_j0[LATENCY-2:0], i_is_j0 & i_valid};
                end
            end
            // The output stage is excluded: that block leaves this cycle, so
            // the drain can finish in step with the final write strobe.
            assign o_any_valid = |r_valid[LATENCY-2:0];
        end
    endgenerate

    assign o_valid = r_valid[LATENCY-1];
    assign o_is_j0 = r_valid[LATENCY-1] & r_is_j0[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/aes_gcm_ctr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : aes_gcm_ctr_scheduler
//  Description : Feeds one AES-GCM message into a non-stalling pipelined
//                AES-256 core: J0 = IV||1 first (tag mask), then IV||2,
//                IV||3, ... Issue is gated by credits mirroring free slots
//                in the downstream keystream FIFO.
//                Ports: clk, reset, bus (aes_gcm_ctr_scheduler_if.slave).
//                Optional feature macro: AES_SCHED_ABORT_EN (abort/aborted).
//  Revision    : 1.0  initial release
// ============================================================================
module aes_gcm_ctr_scheduler
    import aes_sched_pkg::*;
#(
    parameter int AES_LATENCY = 14,
    parameter int OUT_DEPTH   = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    aes_gcm_ctr_scheduler_if.slave  bus
);

    localparam int                  c_cred_w      = $clog2(OUT_DEPTH + 1);
    localparam logic [c_cred_w-1:0] c_credit_full = c_cred_w'(OUT_DEPTH);
    localparam logic [c_cred_w-1:0] c_credit_one  = c_cred_w'(1);

    sched_state_t           r_state;
    sched_state_t           w_state_nxt;
    logic [IV_W-1:0]        r_iv;
    logic [CTR_W-1:0]       r_ctr;
    logic [CTR_W-1:0]       r_remaining;    // data blocks still to issue
    logic [c_cred_w-1:0]    r_credits;
    logic                   r_credit_err;

    logic w_issue;
    logic w_issue_j0;
    logic w_busy;
    logic w_done;
    logic w_abort;
    logic w_abort_take;
    logic w_have_credit;
    logic w_trk_valid;
    logic w_trk_j0;
    logic w_trk_any;

`ifdef AES_SCHED_ABORT_EN
    logic r_aborted;
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_have_credit = (r_credits != '0);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_issue_j0   = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_abort_take = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_ISSUE_J0;
            end
            ST_ISSUE_J0: begin
                w_busy = 1'b1;
                if (w_abort) begin
                    w_abort_take = 1'b1;
                    w_state_nxt  = ST_DRAIN;
                end else if (w_have_credit) begin
                    w_issue     = 1'b1;
                    w_issue_j0  = 1'b1;
                    w_state_nxt = (r_remaining == '0) ? ST_DRAIN : ST_ISSUE_DATA;
                end
            end
            ST_ISSUE_DATA: begin
                w_busy = 1'b1;
                if (w_abort) begin
                    w_abort_take = 1'b1;
                    w_state_nxt  = ST_DRAIN;
                end else if (w_have_credit) begin
                    w_issue = 1'b1;
                    if (r_remaining == 32'd1) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (!w_trk_any) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------- message / counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iv        <= '0;
            r_ctr       <= '0;
            r_remaining <= '0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_iv        <= bus.iv;
            r_ctr       <= J0_CTR;
            r_remaining <= clamp_blocks(bus.num_blocks);
        end else if (w_issue) begin
            if (w_issue_j0) begin
                r_ctr <= DATA_CTR0;
            end else begin
                // inc32: the clamp keeps this from ever wrapping
                r_ctr       <= r_ctr + 32'd1;
                r_remaining <= r_remaining - 32'd1;
            end
        end
    end

`ifdef AES_SCHED_ABORT_EN
    always_ff @(posedge clk) begin
        if (reset)                             r_aborted <= 1'b0;
        else if (r_state == ST_IDLE && bus.start) r_aborted <= 1'b0;
        else if (w_abort_take)                 r_aborted <= 1'b1;
    end
    assign bus.aborted = w_done & r_aborted;
`endif

    // -------------------------------------------------------------- credits
    // One credit per free FIFO slot. Issue and pop in one cycle cancel out;
    // a pop with every slot already free is a consumer error and saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credits    <= c_credit_full;
            r_credit_err <= 1'b0;
        end else begin
            if (bus.ks_pop && r_credits == c_credit_full) r_credit_err <= 1'b1;
            if (w_issue && !bus.ks_pop)
                r_credits <= r_credits - c_credit_one;
            else if (!w_issue && bus.ks_pop && r_credits != c_credit_full)
                r_credits <= r_credits + c_credit_one;
        end
    end

    // -------------------------------------------------------------- tracker
    aes_sched_track #(
        .LATENCY (AES_LATENCY)
    ) u_track (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (w_issue),
        .i_is_j0     (w_issue_j0),
        .o_valid     (w_trk_valid),
        .o_is_j0     (w_trk_j0),
        .o_any_valid (w_trk_any)
    );

    // -------------------------------------------------------------- outputs
    assign bus.aes_in_valid = w_issue;
    assign bus.aes_in_block = w_issue ? {r_iv, r_ctr} : '0;
    assign bus.ks_valid     = w_trk_valid;
    assign bus.ks_is_j0     = w_trk_j0;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.credit_err   = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_gcm_ctr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_gcm_ctr_scheduler
//  Description : Self-checking bench for aes_gcm_ctr_scheduler. A message-
//                level model predicts issues, keystream strobes, done and
//                credits every cycle; directed scenarios add literal checks.
//                Honours AES_SCHED_ABORT_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_gcm_ctr_scheduler;

    localparam int LAT   = 14;
    localparam int DEPTH = 16;
    localparam logic [95:0] IV2 = 96'hCAFEBABEFACEDBADDECAF888;
    localparam logic [95:0] IV3 = 96'h0123456789ABCDEF00112233;

    logic clk;
    logic reset;
    logic tie_pop;
    logic man_pop;
    int   cyc;
    int   n_tests;
    int   n_fail;

    aes_gcm_ctr_scheduler_if bus ();
    aes_gcm_ctr_scheduler_if bus4 ();

    assign bus.ks_pop = tie_pop ? bus.ks_valid : man_pop;

    aes_gcm_ctr_scheduler #(.AES_LATENCY(LAT), .OUT_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    aes_gcm_ctr_scheduler #(.AES_LATENCY(LAT), .OUT_DEPTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------- logs
    int           issue_log[$];
    logic [127:0] blk_log[$];
    int           ks_log[$];
    int           j0_log[$];
    int           done_log[$];
    bit           abort_log[$];
    int           act_cnt;

    task automatic clear_logs();
        issue_log.delete(); blk_log.delete(); ks_log.delete();
        j0_log.delete(); done_log.delete(); abort_log.delete();
        act_cnt = 0;
    endtask

    // ------------------------------------------------------------ model
    bit           m_known, m_active, m_issuing, m_aborted, m_err;
    logic [95:0]  m_iv;
    longint       m_next_ctr, m_last_ctr, m_last_issue, m_done_cyc;
    int           m_credits;
    bit           ks_at[longint];
    bit           j0_at[longint];

    bit           e_issue, e_abort_now, e_ks, e_j0, e_done, e_busy, e_pop, e_abort_in;
    logic [127:0] e_block;
    logic [31:0]  e_n;

    initial begin : p_compare
        m_known = 0; m_active = 0; m_issuing = 0; m_aborted = 0; m_err = 0;
        m_credits = DEPTH; m_done_cyc = -1; m_last_issue = -1000;
        forever begin
            @(negedge clk);
`ifdef AES_SCHED_ABORT_EN
            e_abort_in = bus.abort;
`else
            e_abort_in = 1'b0;
`endif
            e_issue = 0; e_abort_now = 0; e_block = '0;
            if (m_active && m_issuing) begin
                if (e_abort_in) e_abort_now = 1;
                else if (m_credits > 0) begin
                    e_issue = 1;
                    e_block = {m_iv, 32'(m_next_ctr)};
                end
            end
            e_ks   = ks_at.exists(cyc);
            e_j0   = e_ks && j0_at[cyc];
            e_done = m_active && (m_done_cyc == cyc);
            e_busy = m_active && !e_done;

            if (m_known) begin
                chk("aes_in_valid", bus.aes_in_valid, e_issue);
                chk("aes_in_block", bus.aes_in_block, e_block);
                chk("ks_valid",     bus.ks_valid,     e_ks);
                chk("ks_is_j0",     bus.ks_is_j0,     e_j0);
                chk("busy",         bus.busy,         e_busy);
                chk("done",         bus.done,         e_done);
                chk("credit_err",   bus.credit_err,   m_err);
                chk("credits",      dut.r_credits,    m_credits);
`ifdef AES_SCHED_ABORT_EN
                chk("aborted",      bus.aborted,      e_done && m_aborted);
`endif
            end

            if (bus.aes_in_valid === 1'b1) begin
                issue_log.push_back(cyc);
                blk_log.push_back(bus.aes_in_block);
            end
            if (bus.ks_valid === 1'b1) ks_log.push_back(cyc);
            if (bus.ks_is_j0 === 1'b1) j0_log.push_back(cyc);
            if (bus.done === 1'b1) begin
                done_log.push_back(cyc);
`ifdef AES_SCHED_ABORT_EN
                abort_log.push_back(bus.aborted);
`endif
            end
            if ((bus.aes_in_valid | bus.ks_valid | bus.ks_is_j0 | bus.busy |
                 bus.done | bus.credit_err) === 1'b1) act_cnt++;

            // advance the model to the next cycle
            if (reset) begin
                m_known = 1; m_active = 0; m_issuing = 0; m_aborted = 0; m_err = 0;
                m_credits = DEPTH; m_done_cyc = -1; m_last_issue = -1000;
                ks_at.delete(); j0_at.delete();
            end else begin
                e_pop = bus.ks_pop;
                if (e_pop && m_credits == DEPTH) m_err = 1;
                if (e_issue) begin
                    ks_at[cyc + LAT] = 1;
                    j0_at[cyc + LAT] = (m_next_ctr == 1);
                    m_last_issue = cyc;
                    m_next_ctr++;
                    if (m_next_ctr > m_last_ctr) begin
                        m_issuing  = 0;
                        m_done_cyc = cyc + LAT + 1;
                    end
                end
                if (e_abort_now) begin
                    m_issuing  = 0;
                    m_aborted  = 1;
                    m_done_cyc = ((cyc + 1 > m_last_issue + LAT) ? cyc + 1 : m_last_issue + LAT) + 1;
                end
                if (e_issue && !e_pop) m_credits--;
                else if (!e_issue && e_pop && m_credits < DEPTH) m_credits++;
                if (e_done) m_active = 0;
                else if (!m_active && bus.start) begin
                    m_active = 1; m_issuing = 1; m_aborted = 0;
                    m_iv = bus.iv;
                    e_n = (bus.num_blocks > 32'hFFFFFFFE) ? 32'hFFFFFFFE : bus.num_blocks;
                    m_next_ctr = 1;
                    m_last_ctr = longint'(e_n) + 1;
                    m_last_issue = -1000;
                    m_done_cyc = -1;
                end
            end
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int t);
        bus.start = 1'b1;
        t = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_t2(input string tag);
        int t;
        tie_pop = 1'b1;
        bus.iv = IV2;
        bus.num_blocks = 32'd3;
        clear_logs();
        tick();
        pulse_start(t);
        repeat (30) tick();
        chk({tag, "_n_issue"}, issue_log.size(), 4);
        for (int k = 0; k < issue_log.size(); k++) begin
            chk({tag, "_issue_cyc"}, issue_log[k] - t, k + 1);
            chk({tag, "_block"}, blk_log[k], {IV2, 32'(k + 1)});
        end
        chk({tag, "_n_ks"}, ks_log.size(), 4);
        for (int k = 0; k < ks_log.size(); k++)
            chk({tag, "_ks_cyc"}, ks_log[k] - t, 15 + k);
        chk({tag, "_n_j0"}, j0_log.size(), 1);
        if (j0_log.size() > 0) chk({tag, "_j0_cyc"}, j0_log[0] - t, 15);
        chk({tag, "_n_done"}, done_log.size(), 1);
        if (done_log.size() > 0) chk({tag, "_done_cyc"}, done_log[0] - t, 19);
    endtask

    initial begin : p_main
        int t;
        int cnt;
        n_tests = 0; n_fail = 0;
        reset = 1'b1; tie_pop = 1'b0; man_pop = 1'b0;
        bus.start = 0; bus.iv = '0; bus.num_blocks = '0;
        bus4.start = 0; bus4.iv = '0; bus4.num_blocks = '0; bus4.ks_pop = 0;
`ifdef AES_SCHED_ABORT_EN
        bus.abort = 0; bus4.abort = 0;
`endif
        repeat (3) tick();
        reset = 1'b0;

        // 1: quiet after reset
        clear_logs();
        repeat (50) tick();
        chk("t1_credits", dut.r_credits, 16);
        chk("t1_activity", act_cnt, 0);

        // 2: three data blocks, pop tied to ks_valid
        run_t2("t2");

        // 4: J0 only; start while busy ignored
        clear_logs();
        tie_pop = 1'b1;
        bus.iv = IV3;
        bus.num_blocks = 32'd0;
        tick();
        pulse_start(t);
        repeat (3) tick();
        bus.num_blocks = 32'd5;
        pulse_start(cnt);
        repeat (30) tick();
        chk("t4_n_issue", issue_log.size(), 1);
        if (issue_log.size() > 0) begin
            chk("t4_issue_cyc", issue_log[0] - t, 1);
            chk("t4_block", blk_log[0], {IV3, 32'h1});
        end
        chk("t4_n_ks", ks_log.size(), 1);
        if (ks_log.size() > 0) chk("t4_ks_cyc", ks_log[0] - t, 15);
        chk("t4_n_j0", j0_log.size(), 1);
        chk("t4_n_done", done_log.size(), 1);
        if (done_log.size() > 0) chk("t4_done_cyc", done_log[0] - t, 16);

        // 5: pop with all credits free; issue+pop in one cycle
        tie_pop = 1'b0;
        tick();
        man_pop = 1'b1;
        tick();
        man_pop = 1'b0;
        tick();
        chk("t5_err", bus.credit_err, 1);
        chk("t5_sat", dut.r_credits, 16);
        clear_logs();
        bus.num_blocks = 32'd2;
        tick();
        pulse_start(t);
        tick();
        man_pop = 1'b1;
        tick();
        man_pop = 1'b0;
        chk("t5_same_cycle", dut.r_credits, 15);
        repeat (25) tick();
        chk("t5_err_sticky", bus.credit_err, 1);
        chk("t5_left", dut.r_credits, 14);
        chk("t5_n_done", done_log.size(), 1);

        // 6: reset mid-message, then the same message again
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("t6_err_clr", bus.credit_err, 0);
        chk("t6_credits", dut.r_credits, 16);
        tie_pop = 1'b1;
        bus.iv = IV2;
        bus.num_blocks = 32'd3;
        tick();
        pulse_start(t);
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_logs();
        repeat (30) tick();
        chk("t6_no_ks", ks_log.size(), 0);
        chk("t6_no_done", done_log.size(), 0);
        run_t2("t6");

`ifdef AES_SCHED_ABORT_EN
        // abort on the third cycle of issue
        clear_logs();
        bus.num_blocks = 32'd3;
        tick();
        pulse_start(t);
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        repeat (25) tick();
        chk("ab_n_issue", issue_log.size(), 2);
        for (int k = 0; k < issue_log.size(); k++)
            chk("ab_issue_cyc", issue_log[k] - t, k + 1);
        chk("ab_n_done", done_log.size(), 1);
        if (done_log.size() > 0) begin
            chk("ab_done_cyc", done_log[0] - t, 17);
            chk("ab_aborted", abort_log[0], 1);
        end
`endif

        // 3: depth-4 instance, no pops
        bus4.iv = IV3;
        bus4.num_blocks = 32'd10;
        tick();
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        cnt = 0;
        repeat (20) begin
            cnt += int'(bus4.aes_in_valid);
            tick();
        end
        chk("t3_n_issue", cnt, 4);
        bus4.ks_pop = 1'b1;
        chk("t3_stalled", bus4.aes_in_valid, 0);
        tick();
        bus4.ks_pop = 1'b0;
        chk("t3_one_more", bus4.aes_in_valid, 1);
        chk("t3_one_blk", bus4.aes_in_block, {IV3, 32'h5});
        tick();
        cnt = 0;
        repeat (10) begin
            cnt += int'(bus4.aes_in_valid);
            tick();
        end
        chk("t3_stalled_again", cnt, 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
